encoder_core: RTL and testbench

Binary-to-stream encoder for the network datapath. It accepts one vector of NN unsigned binary words over a valid/ready handshake. It then emits 2^WR stream beats, each one bit per lane, in which each lane carries exactly x ones. The ones are spread by a first-order error-feedback (sigma-delta) accumulator. The block feeds the reservoir/hidden stream domain, and the stream decoder at the far end recovers x by counting ones over the same 2^WR-beat window.

---
 rtl/encoder_core.sv | 84 ++++++++
 tb/tb_encoder_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_core.sv
// Binary-to-stream encoder: NN lanes, each word x becomes x ones spread over a 2^WR-beat window.
// Latency: first beat valid 1 cycle after load; backpressure holds beat data, counter and accumulators.
// A new vector is accepted in WAIT or alongside the accepted last beat, giving gap-free windows.
module encoder_core #(
    parameter int NN = 8,
    parameter int WR = 6
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AB,
    output logic             oReady_AB,
    input  logic [NN*WR-1:0] iData_AB,
    output logic             oValid_SS,
    input  logic             iReady_SS,
    output logic [NN-1:0]    oData_SS,
    output logic             oLast_SS
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state;
    logic [WR-1:0]   rx   [NN];
    logic [WR-1:0]   racc [NN];
    logic [WR-1:0]   rcnt;
    logic [WR:0]     sum  [NN];
    logic [NN-1:0]   carry;
    logic            load;
    logic            beat_acc;
    logic            last_beat;

    // Outputs are forced low while reset is held so the reset cycle itself is quiet.
    assign oValid_SS = (state == STREAM) && !iRST;
    assign last_beat = (rcnt == '1);
    assign oLast_SS  = oValid_SS && last_beat;
    assign beat_acc  = oValid_SS && iReady_SS;
    assign oReady_AB = !iRST && ((state == WAIT) || (state == STREAM && last_beat && iReady_SS));
    assign load      = iValid_AB && oReady_AB;

    // First-order error feedback: the carry out of racc + rx is the emitted bit.
    always_comb begin
        for (int i = 0; i < NN; i++) begin
            sum[i]   = {1'b0, racc[i]} + {1'b0, rx[i]};
            carry[i] = sum[i][WR];
        end
    end

    assign oData_SS = carry & {NN{oValid_SS}};

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
            rcnt  <= '0;
            for (int i = 0; i < NN; i++) begin
                racc[i] <= '0;
            end
        end else begin
            case (state)
                IDLE:    state <= WAIT;
                WAIT:    if (load) state <= STREAM;
                STREAM:  if (beat_acc && last_beat && !load) state <= WAIT;
                default: state <= IDLE;
            endcase

            // A coincident load wins over the final beat update; that beat already left.
            if (load) begin
                rcnt <= '0;
                for (int i = 0; i < NN; i++) begin
                    rx[i]   <= iData_AB[i*WR +: WR];
                    racc[i] <= '0;
                end
            end else if (beat_acc) begin
                rcnt <= rcnt + 1'b1;
                for (int i = 0; i < NN; i++) begin
                    racc[i] <= sum[i][WR-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_encoder_core.sv
// Scoreboard bench for encoder_core: expected beats are queued at each accepted load and
// popped by an independent monitor; a per-window ones-count decoder checks recovery of x.
module tb_encoder_core;

    localparam int NN  = 8;
    localparam int WR  = 6;
    localparam int WIN = 64;

    logic             iCLK;
    logic             iRST;
    logic             iValid_AB;
    logic             oReady_AB;
    logic [NN*WR-1:0] iData_AB;
    logic             oValid_SS;
    logic             iReady_SS;
    logic [NN-1:0]    oData_SS;
    logic             oLast_SS;

    encoder_core #(.NN(NN), .WR(WR)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iValid_AB (iValid_AB),
        .oReady_AB (oReady_AB),
        .iData_AB  (iData_AB),
        .oValid_SS (oValid_SS),
        .iReady_SS (iReady_SS),
        .oData_SS  (oData_SS),
        .oLast_SS  (oLast_SS)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_err = 0;
    int rdy_pct = 100;

    logic [NN:0]      beat_q [$];
    logic [NN*WR-1:0] win_q  [$];

    int          cnt [NN];
    logic        prev_stall;
    logic [NN-1:0] prev_dat;
    logic        prev_last;
    int          run_len;
    int          max_run;

    // Closed form of the ideal stream: lane bit at beat k is floor((k+1)x/W) - floor(kx/W).
    function automatic logic [NN-1:0] exp_bits(input logic [NN*WR-1:0] v, input int k);
        logic [NN-1:0] b;
        int x;
        b = '0;
        for (int i = 0; i < NN; i++) begin
            x = int'(v[i*WR +: WR]);
            b[i] = ((((k + 1) * x) / WIN) - ((k * x) / WIN)) != 0;
        end
        return b;
    endfunction

    function automatic logic [NN*WR-1:0] rand_vec();
        logic [NN*WR-1:0] v;
        for (int i = 0; i < NN; i++) v[i*WR +: WR] = WR'($urandom_range(WIN - 1));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Ready driver, updated just after each rising edge.
    initial begin
        iReady_SS = 1'b1;
        forever begin
            @(posedge iCLK);
            #1;
            iReady_SS = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: pops one expected beat per accepted beat and decodes each window.
    always @(negedge iCLK) begin
        logic [NN:0]      e;
        logic [NN*WR-1:0] w;
        int bad;
        if (iRST) begin
            for (int i = 0; i < NN; i++) cnt[i] = 0;
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!(oValid_SS && oData_SS == prev_dat && oLast_SS == prev_last)) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b",
                             oValid_SS, oData_SS, oLast_SS, prev_dat, prev_last);
                end
            end
            if (oValid_SS && iReady_SS) begin
                n_vec++;
                if (beat_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got d=%0h l=%0b, expected no beat", oData_SS, oLast_SS);
                end else begin
                    e = beat_q.pop_front();
                    if ({oLast_SS, oData_SS} !== e) begin
                        n_err++;
                        $display("FAIL beat: got last=%0b data=%0h, expected last=%0b data=%0h",
                                 oLast_SS, oData_SS, e[NN], e[NN-1:0]);
                    end
                    for (int i = 0; i < NN; i++) cnt[i] += int'(oData_SS[i]);
                    if (e[NN]) begin
                        w = win_q.pop_front();
                        bad = 0;
                        for (int i = 0; i < NN; i++) if (cnt[i] != int'(w[i*WR +: WR])) bad++;
                        n_vec++;
                        if (bad != 0) begin
                            n_err++;
                            $display("FAIL decode: got lane0..3 counts %0d %0d %0d %0d, expected word %0h",
                                     cnt[0], cnt[1], cnt[2], cnt[3], w);
                        end
                        for (int i = 0; i < NN; i++) cnt[i] = 0;
                    end
                end
            end
            run_len = oValid_SS ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            prev_stall = oValid_SS && !iReady_SS;
            prev_dat   = oData_SS;
            prev_last  = oLast_SS;
        end
    end

    // Presents v until accepted, then queues its expected window. Valid stays high.
    task automatic load(input logic [NN*WR-1:0] v, output logic last_at_acc);
        int t;
        t = 0;
        last_at_acc = 1'b0;
        @(posedge iCLK);
        #1;
        iValid_AB = 1'b1;
        iData_AB  = v;
        forever begin
            @(negedge iCLK);
            if (iValid_AB && oReady_AB) break;
            t++;
            if (t > 2000) begin
                n_vec++;
                n_err++;
                $display("FAIL load_timeout: got no accept in %0d cycles, expected accept", t);
                return;
            end
        end
        last_at_acc = oLast_SS;
        for (int k = 0; k < WIN; k++) beat_q.push_back({k == WIN - 1, exp_bits(v, k)});
        win_q.push_back(v);
    endtask

    task automatic idle();
        @(posedge iCLK);
        #1;
        iValid_AB = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        forever begin
            @(negedge iCLK);
            if (beat_q.size() == 0 && !oValid_SS) break;
            t++;
            if (t > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL drain_timeout: got %0d beats pending, expected 0", beat_q.size());
                break;
            end
        end
    endtask

    initial begin
        logic la;
        logic [NN*WR-1:0] v;
        int t;

        iRST      = 1'b1;
        iValid_AB = 1'b0;
        iData_AB  = '0;
        max_run   = 0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_outputs", {oReady_AB, oValid_SS, oLast_SS, oData_SS}, '0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        @(negedge iCLK);
        check("idle_outputs", {oReady_AB, oValid_SS, oLast_SS, oData_SS}, '0);
        @(negedge iCLK);
        check("wait_ready", oReady_AB, 1);

        // All-zero window; ready must come back with the last beat.
        rdy_pct = 100;
        load('0, la);
        idle();
        t = 0;
        while (!oLast_SS && t < 200) begin
            @(negedge iCLK);
            t++;
        end
        check("ready_on_last", oReady_AB, 1);
        drain();

        // Directed lanes: 63, 32, 1, 0 plus mixed upper lanes.
        v = {6'd9, 6'd40, 6'd17, 6'd5, 6'd0, 6'd1, 6'd32, 6'd63};
        load(v, la);
        idle();
        drain();

        // Random backpressure with random vectors, one window at a time.
        rdy_pct = 50;
        for (int n = 0; n < 6; n++) begin
            load(rand_vec(), la);
            idle();
            drain();
        end

        // Back-to-back: three windows, valid held high throughout.
        rdy_pct = 100;
        max_run = 0;
        load({6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8}, la);
        load({6'd63, 6'd0, 6'd63, 6'd0, 6'd31, 6'd33, 6'd48, 6'd16}, la);
        check("b2b_load2_on_last", la, 1);
        load({6'd10, 6'd20, 6'd30, 6'd40, 6'd50, 6'd60, 6'd62, 6'd11}, la);
        check("b2b_load3_on_last", la, 1);
        idle();
        drain();
        check("b2b_no_gap", max_run, 3 * WIN);

        // Reset in the middle of a window.
        load({6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7}, la);
        idle();
        repeat (20) @(negedge iCLK);
        check("mid_valid", oValid_SS, 1);
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        beat_q.delete();
        win_q.delete();
        @(negedge iCLK);
        check("mid_rst_valid", oValid_SS, 0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        @(negedge iCLK);
        check("post_rst_idle", {oValid_SS, oReady_AB}, 0);
        @(negedge iCLK);
        check("post_rst_ready", oReady_AB, 1);
        load({6'd60, 6'd3, 6'd32, 6'd1, 6'd62, 6'd15, 6'd47, 6'd63}, la);
        idle();
        drain();

        // Loopback decode of random back-to-back vectors under random backpressure.
        rdy_pct = 50;
        for (int n = 0; n < 400; n++) load(rand_vec(), la);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
